// File: rtl/serial_receiver_pkg.sv
// Shared serial frame definitions.
// Receive FSM states and default frame format.
package serial_receiver_pkg;

  localparam int SPB_DEFAULT       = 16;
  localparam int DATA_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/serial_receiver_sipo.sv
// Serial-in/parallel-out register.
// Shifts right so the first bit received lands in the LSB.
module sipo_shift_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] pout
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) sr_d = {sin, sr_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign pout = sr_q;

endmodule

// File: rtl/serial_receiver.sv
// Oversampling asynchronous serial receiver.
// Mid-bit sampling, LSB-first, valid/ack handshake.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = SPB_DEFAULT,
  parameter int DATA_BITS       = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 r_enable,
  input  logic                 data_in,
  input  logic                 char_read,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 char_received,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(SAMPLES_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(DATA_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 crx_q, crx_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 shift_en;
  logic                 good;
  logic                 bad;
  logic [DATA_BITS-1:0] sr;

  assign sync_d = {sync_q[0], data_in};
  assign rx_s   = sync_q[1];

  sipo_shift_register #(
    .W(DATA_BITS)
  ) u_sipo (
    .clk     (clk),
    .rst_n   (reset),
    .shift_en(shift_en),
    .sin     (rx_s),
    .pout    (sr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_en = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    if (!r_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            if (!rx_s) begin
              state_d = DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            shift_en = 1'b1;
            cnt_d    = '0;
            idx_d    = idx_q + IW'(1);
            if (idx_q == LAST_IDX) state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            state_d = IDLE;
            good    = rx_s;
            bad     = !rx_s;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A read coinciding with a load acknowledges the old char, not the new one
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    crx_d      = good;
    ferr_d     = bad;
    if (char_read) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (good) begin
      data_out_d = sr;
      valid_d    = 1'b1;
      if (valid_q && !char_read) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      crx_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      crx_q      <= crx_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = valid_q;
  assign char_received = crx_q;
  assign frame_error   = ferr_q;
  assign overrun       = ovr_q;

endmodule
